// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction word, program-loader FSM states and
// the default frame start marker.
package cpu_pkg;

   typedef logic [31:0] instr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian 8->32 shift-in; word_valid_o pulses with the
// 4th byte, and word_o is valid in that same cycle.
module byte_packer
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       valid_i,
   input  logic [7:0] byte_i,
   output instr_t     word_o,
   output logic       word_valid_o
);

   logic [1:0]  cnt_q;
   logic [23:0] sh_q;

   assign word_o       = {byte_i, sh_q};
   assign word_valid_o = valid_i && !clear_i && (cnt_q == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         sh_q  <= 24'd0;
      end else if (clear_i) begin
         cnt_q <= 2'd0;
         sh_q  <= 24'd0;
      end else if (valid_i) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= {byte_i, sh_q[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader into instruction memory; holds the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned BASE_ADDR   = 0,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output instr_t            imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   loader_state_t     state_q;
   logic [15:0]       len_q, idx_q;
   logic [31:0]       tmo_q;
   logic [7:0]        chk_q;
   logic              bad_q, we_q, hold_q, done_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   instr_t            wdata_q;

   logic   acc, timed, tmo_hit, last, in_range, to_done, fin_bad;
   logic   pk_valid, pk_clear, pk_wv;
   instr_t pk_word;
   logic [31:0] waddr;

   assign in_ready   = !(state_q inside {S_WRITE, S_DONE});
   assign acc        = in_valid && in_ready;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

   assign timed   = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
   assign tmo_hit = (TIMEOUT_CYC != 0) && timed && !acc
                    && (tmo_q == TIMEOUT_CYC - 32'd1);
   assign last    = ({1'b0, idx_q} + 17'd1) == {1'b0, len_q};
   // Out-of-range words are dropped; the address is never allowed to wrap.
   assign waddr    = BASE_ADDR + {16'd0, idx_q};
   assign in_range = waddr < (32'd1 << ADDR_W);

   assign pk_clear = (state_q == S_IDLE);
   assign pk_valid = acc && (state_q == S_DATA);

   byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (pk_clear),
      .valid_i      (pk_valid),
      .byte_i       (in_data),
      .word_o       (pk_word),
      .word_valid_o (pk_wv)
   );

   always_comb begin
      to_done = 1'b0;
      fin_bad = bad_q;
      unique case (state_q)
         S_LEN_HI: to_done = acc && !CHK_EN
                             && ({in_data, len_q[7:0]} == 16'd0);
         S_WRITE:  to_done = last && !CHK_EN;
         S_CHK: begin
            to_done = acc;
            fin_bad = bad_q || (in_data != chk_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         tmo_q   <= 32'd0;
         chk_q   <= 8'd0;
         bad_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         if (timed && !acc) tmo_q <= tmo_q + 32'd1;
         else               tmo_q <= 32'd0;

         if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: if (acc && in_data == SYNC_BYTE) begin
                  hold_q  <= 1'b1;
                  err_q   <= 1'b0;
                  bad_q   <= 1'b0;
                  chk_q   <= 8'd0;
                  idx_q   <= 16'd0;
                  state_q <= S_LEN_LO;
               end
               S_LEN_LO: if (acc) begin
                  len_q[7:0] <= in_data;
                  chk_q      <= chk_q ^ in_data;
                  state_q    <= S_LEN_HI;
               end
               S_LEN_HI: if (acc) begin
                  len_q[15:8] <= in_data;
                  chk_q       <= chk_q ^ in_data;
                  if ({in_data, len_q[7:0]} == 16'd0)
                     state_q <= CHK_EN ? S_CHK : S_DONE;
                  else
                     state_q <= S_DATA;
               end
               S_DATA: if (acc) begin
                  chk_q <= chk_q ^ in_data;
                  if (pk_wv) begin
                     wdata_q <= pk_word;
                     state_q <= S_WRITE;
                     if (in_range) begin
                        we_q   <= 1'b1;
                        addr_q <= waddr[ADDR_W-1:0];
                     end else begin
                        bad_q  <= 1'b1;
                     end
                  end
               end
               S_WRITE: begin
                  idx_q <= idx_q + 16'd1;
                  if (!last)       state_q <= S_DATA;
                  else if (CHK_EN) state_q <= S_CHK;
                  else             state_q <= S_DONE;
               end
               S_CHK: if (acc) state_q <= S_DONE;
               S_DONE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase

            // A failed load keeps the CPU held so a partial program never runs.
            if (to_done) begin
               if (fin_bad) err_q <= 1'b1;
               else begin
                  done_q <= 1'b1;
                  hold_q <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2 so overflow is reachable,
// TIMEOUT_CYC=16); checksum frames added when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [1:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   int compared = 0;
   int mismatched = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   logic [1:0]  wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   logic [7:0]  cks;

   imem_loader #(
      .ADDR_W      (2),
      .BASE_ADDR   (0),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we && wr_cnt < 64) begin
         wr_addr[wr_cnt] = imem_addr;
         wr_data[wr_cnt] = imem_wdata;
      end
      if (imem_we) wr_cnt = wr_cnt + 1;
      if (load_done) done_cnt = done_cnt + 1;
   end

   task automatic send(input logic [7:0] b);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL send_ready got=0 want=1 byte=%h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cks = cks ^ b;
   endtask

   task automatic send_sync();
      send(8'hA5);
      cks = 8'h00;
   endtask

   task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(cks);
`endif
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      if (in_ready !== 1'b1) begin
         mismatched++; $display("FAIL rst_ready got=%b want=1", in_ready);
      end
      compared++;
      if (imem_we !== 1'b0) begin
         mismatched++; $display("FAIL rst_we got=%b want=0", imem_we);
      end
      compared++;
      if (imem_addr !== 2'd0) begin
         mismatched++; $display("FAIL rst_addr got=%h want=0", imem_addr);
      end
      compared++;
      if (imem_wdata !== 32'd0) begin
         mismatched++; $display("FAIL rst_wdata got=%h want=0", imem_wdata);
      end
      compared++;
      if (cpu_hold !== 1'b0) begin
         mismatched++; $display("FAIL rst_hold got=%b want=0", cpu_hold);
      end
      compared++;
      if (load_done !== 1'b0) begin
         mismatched++; $display("FAIL rst_done got=%b want=0", load_done);
      end
      compared++;
      if (load_err !== 1'b0) begin
         mismatched++; $display("FAIL rst_err got=%b want=0", load_err);
      end
      compared++;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      send_sync();
      if (cpu_hold !== 1'b1) begin
         mismatched++; $display("FAIL basic_hold_on got=%b want=1", cpu_hold);
      end
      compared++;
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      if (imem_we !== 1'b1) begin
         mismatched++; $display("FAIL basic_latency got=%b want=1", imem_we);
      end
      compared++;
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      finish_frame();
      if (wr_cnt - w0 !== 2) begin
         mismatched++; $display("FAIL basic_wrcnt got=%0d want=2", wr_cnt - w0);
      end
      compared++;
      if (wr_addr[w0] !== 2'd0 || wr_data[w0] !== 32'h00000013) begin
         mismatched++;
         $display("FAIL basic_w0 got=%h@%h want=00000013@0", wr_data[w0], wr_addr[w0]);
      end
      compared++;
      if (wr_addr[w0+1] !== 2'd1 || wr_data[w0+1] !== 32'h00100093) begin
         mismatched++;
         $display("FAIL basic_w1 got=%h@%h want=00100093@1", wr_data[w0+1], wr_addr[w0+1]);
      end
      compared++;
      if (done_cnt - d0 !== 1) begin
         mismatched++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0);
      end
      compared++;
      if (cpu_hold !== 1'b0 || load_err !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_end got=hold%b/err%b want=hold0/err0", cpu_hold, load_err);
      end
      compared++;
   endtask

   task automatic test_junk();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      send(8'h00); send(8'hFF);
      if (cpu_hold !== 1'b0) begin
         mismatched++; $display("FAIL junk_hold got=%b want=0", cpu_hold);
      end
      compared++;
      send_sync();
      send(8'h01); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      finish_frame();
      if (wr_cnt - w0 !== 1) begin
         mismatched++; $display("FAIL junk_wrcnt got=%0d want=1", wr_cnt - w0);
      end
      compared++;
      if (wr_addr[w0] !== 2'd0 || wr_data[w0] !== 32'h12345678) begin
         mismatched++;
         $display("FAIL junk_w0 got=%h@%h want=12345678@0", wr_data[w0], wr_addr[w0]);
      end
      compared++;
      if (done_cnt - d0 !== 1) begin
         mismatched++; $display("FAIL junk_done got=%0d want=1", done_cnt - d0);
      end
      compared++;
   endtask

   task automatic test_toggle();
      int w0 = wr_cnt;
      logic [7:0] bytes [0:7];
      bytes = '{8'hA5, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_sync();
      send(8'h02); send(8'h00);
      for (int i = 0; i < 8; i++) begin
         send(bytes[i]);
         @(posedge clk);
         #1;
      end
      finish_frame();
      if (wr_cnt - w0 !== 2) begin
         mismatched++; $display("FAIL toggle_wrcnt got=%0d want=2", wr_cnt - w0);
      end
      compared++;
      if (wr_data[w0] !== 32'h443322A5) begin
         mismatched++; $display("FAIL toggle_w0 got=%h want=443322a5", wr_data[w0]);
      end
      compared++;
      if (wr_data[w0+1] !== 32'h88776655) begin
         mismatched++; $display("FAIL toggle_w1 got=%h want=88776655", wr_data[w0+1]);
      end
      compared++;
      if (cpu_hold !== 1'b0) begin
         mismatched++; $display("FAIL toggle_hold got=%b want=0", cpu_hold);
      end
      compared++;
   endtask

   task automatic test_timeout();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      int seen = 0;
      send_sync();
      send(8'h02); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (load_err && seen == 0) seen = i;
      end
      if (seen !== 16) begin
         mismatched++; $display("FAIL tmo_cycles got=%0d want=16", seen);
      end
      compared++;
      if (wr_cnt - w0 !== 1 || wr_data[w0] !== 32'h04030201) begin
         mismatched++;
         $display("FAIL tmo_writes got=%0d/%h want=1/04030201", wr_cnt - w0, wr_data[w0]);
      end
      compared++;
      if (cpu_hold !== 1'b1) begin
         mismatched++; $display("FAIL tmo_hold got=%b want=1", cpu_hold);
      end
      compared++;
      if (done_cnt - d0 !== 0) begin
         mismatched++; $display("FAIL tmo_done got=%0d want=0", done_cnt - d0);
      end
      compared++;
   endtask

   task automatic test_overflow();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      send_sync();
      if (load_err !== 1'b0) begin
         mismatched++; $display("FAIL ovf_errclr got=%b want=0", load_err);
      end
      compared++;
      send(8'h05); send(8'h00);
      for (int i = 0; i < 20; i++) send(8'(i + 1));
      finish_frame();
      if (wr_cnt - w0 !== 4) begin
         mismatched++; $display("FAIL ovf_wrcnt got=%0d want=4", wr_cnt - w0);
      end
      compared++;
      if (wr_addr[w0+3] !== 2'd3 || wr_data[w0+3] !== 32'h100F0E0D) begin
         mismatched++;
         $display("FAIL ovf_w3 got=%h@%h want=100f0e0d@3", wr_data[w0+3], wr_addr[w0+3]);
      end
      compared++;
      if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_end got=err%b/hold%b want=err1/hold1", load_err, cpu_hold);
      end
      compared++;
      if (done_cnt - d0 !== 0) begin
         mismatched++; $display("FAIL ovf_done got=%0d want=0", done_cnt - d0);
      end
      compared++;
   endtask

   task automatic test_recover();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      send_sync();
      send(8'h01); send(8'h00);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      finish_frame();
      if (wr_data[w0] !== 32'hDEADBEEF || wr_cnt - w0 !== 1) begin
         mismatched++; $display("FAIL rec_w0 got=%h want=deadbeef", wr_data[w0]);
      end
      compared++;
      if (done_cnt - d0 !== 1) begin
         mismatched++; $display("FAIL rec_done got=%0d want=1", done_cnt - d0);
      end
      compared++;
      if (cpu_hold !== 1'b0 || load_err !== 1'b0) begin
         mismatched++;
         $display("FAIL rec_end got=hold%b/err%b want=hold0/err0", cpu_hold, load_err);
      end
      compared++;
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      send_sync();
      send(8'h01); send(8'h00);
      send(8'h11); send(8'h22); send(8'h44); send(8'h88);
      send(8'h00);
      repeat (6) @(posedge clk);
      #1;
      if (load_err !== 1'b1 || cpu_hold !== 1'b1 || done_cnt - d0 !== 0) begin
         mismatched++;
         $display("FAIL cks_bad got=err%b/hold%b want=err1/hold1", load_err, cpu_hold);
      end
      compared++;
      if (wr_cnt - w0 !== 1) begin
         mismatched++; $display("FAIL cks_bad_wr got=%0d want=1", wr_cnt - w0);
      end
      compared++;
      d0 = done_cnt;
      send_sync();
      send(8'h01); send(8'h00);
      send(8'h11); send(8'h22); send(8'h44); send(8'h88);
      send(8'hFE);
      repeat (6) @(posedge clk);
      #1;
      if (done_cnt - d0 !== 1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
         mismatched++;
         $display("FAIL cks_good got=done%0d/hold%b want=done1/hold0", done_cnt - d0, cpu_hold);
      end
      compared++;
   endtask
`endif

   initial begin
      cks = 8'h00;
      test_reset();
      test_basic();
      test_junk();
      test_toggle();
      test_timeout();
      test_overflow();
      test_recover();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
